mgmt_ram_arbiter: RTL and testbench

Two-master Wishbone arbiter and sequencer for the management-area R/W RAM interface. It sits between the CPU data bus (m0) and a secondary master such as a housekeeping/debug DMA (m1), and the RAM_BLOCKS-wide RAM port bundle (ena/wen/wen_mask/addr/wdata/rdata). It selects one requester at a time with round-robin fairness and issues registered RAM strobes. It steers the synchronous-read data back to the requester and generates a single-cycle ack.

---
 rtl/mgmt_ram_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_mgmt_ram_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mgmt_ram_arbiter.sv
// mgmt_ram_arbiter
//   Two-master Wishbone arbiter and sequencer for the management-area R/W RAM.
//   One transaction at a time walks IDLE -> ISSUE -> DATA -> RESP. Masters are
//   picked round-robin. The RAM strobes are registered and issued for one cycle.
//   The synchronous-read data is steered back to the owner with a one-cycle ack.
//
// Ports
//   clk, resetn        : clock, synchronous active-low reset
//   mN_cyc_i/stb_i/we_i: Wishbone control for master N (0 = CPU, 1 = secondary)
//   mN_sel_i           : byte selects
//   mN_adr_i           : byte address (only word/block bits are decoded)
//   mN_dat_i           : write data
//   mN_ack_o           : single-cycle ack to the owning master
//   mN_dat_o           : read data, held until that master's next response
//   mgmt_ena/wen       : per-block enable / write enable
//   mgmt_wen_mask      : per-block byte write mask (4 bits per block)
//   mgmt_addr/wdata    : shared word address and write data
//   mgmt_rdata         : per-block read data, valid the cycle after ena
//   grant              : one-hot current owner, 00 when idle
module mgmt_ram_arbiter #(
  parameter int RAM_BLOCKS = 2,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     m0_cyc_i,
  input  logic                     m0_stb_i,
  input  logic                     m0_we_i,
  input  logic [3:0]               m0_sel_i,
  input  logic [31:0]              m0_adr_i,
  input  logic [31:0]              m0_dat_i,
  output logic                     m0_ack_o,
  output logic [31:0]              m0_dat_o,
  input  logic                     m1_cyc_i,
  input  logic                     m1_stb_i,
  input  logic                     m1_we_i,
  input  logic [3:0]               m1_sel_i,
  input  logic [31:0]              m1_adr_i,
  input  logic [31:0]              m1_dat_i,
  output logic                     m1_ack_o,
  output logic [31:0]              m1_dat_o,
  output logic [RAM_BLOCKS-1:0]    mgmt_ena,
  output logic [RAM_BLOCKS-1:0]    mgmt_wen,
  output logic [RAM_BLOCKS*4-1:0]  mgmt_wen_mask,
  output logic [ADDR_WIDTH-1:0]    mgmt_addr,
  output logic [31:0]              mgmt_wdata,
  input  logic [RAM_BLOCKS*32-1:0] mgmt_rdata,
  output logic [1:0]               grant
);

  localparam int BLK_BITS = (RAM_BLOCKS > 1) ? $clog2(RAM_BLOCKS) : 0;
  // Block index is kept at least one bit wide so a single-block build still has a legal signal.
  localparam int BW = (BLK_BITS > 0) ? BLK_BITS : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic                    ptr_q, ptr_d;
  logic [1:0]              grant_q, grant_d;
  logic                    we_q, we_d;
  logic [BW-1:0]           blk_q, blk_d;
  logic [RAM_BLOCKS-1:0]   ena_q, ena_d;
  logic [RAM_BLOCKS-1:0]   wen_q, wen_d;
  logic [RAM_BLOCKS*4-1:0] mask_q, mask_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [1:0]              ack_q, ack_d;
  logic [31:0]             dat0_q, dat0_d;
  logic [31:0]             dat1_q, dat1_d;

  logic                    m0_req, m1_req;
  logic [ADDR_WIDTH-1:0]   m0_word, m1_word;
  logic [BW-1:0]           m0_blk, m1_blk;
  logic                    pick_m1;
  logic                    owner_cyc;
  logic [31:0]             rd_word;
  logic                    unused_adr;

  assign m0_req  = m0_cyc_i & m0_stb_i;
  assign m1_req  = m1_cyc_i & m1_stb_i;
  assign m0_word = m0_adr_i[ADDR_WIDTH+1:2];
  assign m1_word = m1_adr_i[ADDR_WIDTH+1:2];

  // Byte-lane and range bits above the block select are qualified upstream.
  assign unused_adr = ^{m0_adr_i, m1_adr_i};

  generate
    if (BLK_BITS > 0) begin : g_blk
      assign m0_blk = m0_adr_i[ADDR_WIDTH+BLK_BITS+1:ADDR_WIDTH+2];
      assign m1_blk = m1_adr_i[ADDR_WIDTH+BLK_BITS+1:ADDR_WIDTH+2];
    end else begin : g_no_blk
      assign m0_blk = '0;
      assign m1_blk = '0;
    end
  endgenerate

  // Abort detection only looks at cyc of the master that currently owns the RAM.
  assign owner_cyc = grant_q[1] ? m1_cyc_i : m0_cyc_i;
  assign rd_word   = mgmt_rdata[{blk_q, 5'b00000} +: 32];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    we_d    = we_q;
    blk_d   = blk_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ena_d   = '0;
    wen_d   = '0;
    mask_d  = '0;
    ack_d   = '0;
    dat0_d  = dat0_q;
    dat1_d  = dat1_q;
    pick_m1 = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // ptr_q = 1 means m1 wins a tie.
          pick_m1 = m1_req && (!m0_req || ptr_q);
          grant_d = pick_m1 ? 2'b10 : 2'b01;
          we_d    = pick_m1 ? m1_we_i : m0_we_i;
          blk_d   = pick_m1 ? m1_blk : m0_blk;
          addr_d  = pick_m1 ? m1_word : m0_word;
          wdata_d = pick_m1 ? m1_dat_i : m0_dat_i;
          // The strobes are loaded here so they are visible during ISSUE.
          ena_d[blk_d] = 1'b1;
          wen_d[blk_d] = we_d;
          if (we_d) begin
            mask_d[{blk_d, 2'b00} +: 4] = pick_m1 ? m1_sel_i : m0_sel_i;
          end
          state_d = ISSUE;
        end
      end
      ISSUE, DATA: begin
        if (!owner_cyc) begin
          // Abandoned by the owner. The RAM access already happened. Drop the ack, but still rotate.
          state_d = IDLE;
          grant_d = 2'b00;
          ptr_d   = grant_q[0];
        end else if (state_q == ISSUE) begin
          state_d = DATA;
        end else begin
          if (grant_q[1]) begin
            dat1_d = we_q ? 32'd0 : rd_word;
          end else begin
            dat0_d = we_q ? 32'd0 : rd_word;
          end
          ack_d   = grant_q;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        grant_d = 2'b00;
        ptr_d   = grant_q[0];
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      grant_q <= 2'b00;
      we_q    <= 1'b0;
      blk_q   <= '0;
      ena_q   <= '0;
      wen_q   <= '0;
      mask_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 2'b00;
      dat0_q  <= '0;
      dat1_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      blk_q   <= blk_d;
      ena_q   <= ena_d;
      wen_q   <= wen_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      dat0_q  <= dat0_d;
      dat1_q  <= dat1_d;
    end
  end

  assign mgmt_ena      = ena_q;
  assign mgmt_wen      = wen_q;
  assign mgmt_wen_mask = mask_q;
  assign mgmt_addr     = addr_q;
  assign mgmt_wdata    = wdata_q;
  assign grant         = grant_q;
  assign m0_ack_o      = ack_q[0];
  assign m1_ack_o      = ack_q[1];
  assign m0_dat_o      = dat0_q;
  assign m1_dat_o      = dat1_q;

endmodule

// File: tb/tb_mgmt_ram_arbiter.sv
// tb_mgmt_ram_arbiter
//   Self-checking bench for mgmt_ram_arbiter with two RAM blocks of 256 words.
//   The stimulus pushes expected RAM strobes and acks into queues. The monitor
//   pops and compares them whenever the DUT shows a strobe or an ack. A
//   behavioural RAM model answers reads. A separate shadow memory provides the
//   expected read data.
module tb_mgmt_ram_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } txn_t;

  typedef struct packed {
    logic [1:0]  grant;
    logic [1:0]  ena;
    logic [1:0]  wen;
    logic [7:0]  mask;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } strobe_t;

  typedef struct packed {
    logic [1:0]  ack;
    logic [31:0] data;
  } ack_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0Cyc, m0Stb, m0We, m1Cyc, m1Stb, m1We;
  logic [3:0]  m0Sel, m1Sel;
  logic [31:0] m0Adr, m0Dat, m1Adr, m1Dat;
  logic        m0Ack, m1Ack;
  logic [31:0] m0DatO, m1DatO;
  logic [1:0]  mgmtEna, mgmtWen, grant;
  logic [7:0]  mgmtWenMask, mgmtAddr;
  logic [31:0] mgmtWdata;
  logic [63:0] ramRdata = '0;

  logic [31:0] ramMem [0:1][0:255];
  logic [31:0] refMem [0:1][0:255];
  strobe_t     strobeQ [$];
  ack_t        ackQ [$];
  logic [31:0] lastDat [0:1];
  int          favour = 0;
  int          checks = 0;
  int          errors = 0;
  int          cycleCnt = 0;
  int          lastStrobeCycle = -1;
  int          lastAckCycle = -1;

  strobe_t     monS;
  ack_t        monA;
  logic [1:0]  monAckVec;
  int          monOwner;

  mgmt_ram_arbiter #(.RAM_BLOCKS(2), .ADDR_WIDTH(8)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .m0_cyc_i      (m0Cyc),
    .m0_stb_i      (m0Stb),
    .m0_we_i       (m0We),
    .m0_sel_i      (m0Sel),
    .m0_adr_i      (m0Adr),
    .m0_dat_i      (m0Dat),
    .m0_ack_o      (m0Ack),
    .m0_dat_o      (m0DatO),
    .m1_cyc_i      (m1Cyc),
    .m1_stb_i      (m1Stb),
    .m1_we_i       (m1We),
    .m1_sel_i      (m1Sel),
    .m1_adr_i      (m1Adr),
    .m1_dat_i      (m1Dat),
    .m1_ack_o      (m1Ack),
    .m1_dat_o      (m1DatO),
    .mgmt_ena      (mgmtEna),
    .mgmt_wen      (mgmtWen),
    .mgmt_wen_mask (mgmtWenMask),
    .mgmt_addr     (mgmtAddr),
    .mgmt_wdata    (mgmtWdata),
    .mgmt_rdata    (ramRdata),
    .grant         (grant)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Synchronous RAM: read data appears the cycle after ena. Writes are byte-masked.
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (mgmtEna[b]) begin
        ramRdata[b*32 +: 32] <= ramMem[b][mgmtAddr];
        if (mgmtWen[b]) begin
          for (int k = 0; k < 4; k++) begin
            if (mgmtWenMask[b*4+k]) ramMem[b][mgmtAddr][8*k +: 8] = mgmtWdata[8*k +: 8];
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  // Reference model: the transaction m is served next. It pushes the strobe and ack that must appear.
  task automatic modelTxn(input int m, input txn_t t, input bit acked);
    int          blk;
    int          word;
    strobe_t     s;
    ack_t        a;
    logic [31:0] rd;
    blk = int'(t.adr[10]);
    word = int'(t.adr[9:2]);
    s = '0;
    s.grant[m] = 1'b1;
    s.ena[blk] = 1'b1;
    s.wen[blk] = t.we;
    if (t.we) s.mask[blk*4 +: 4] = t.sel;
    s.addr = t.adr[9:2];
    s.wdata = t.dat;
    strobeQ.push_back(s);
    rd = 32'd0;
    if (t.we) begin
      for (int k = 0; k < 4; k++) begin
        if (t.sel[k]) refMem[blk][word][8*k +: 8] = t.dat[8*k +: 8];
      end
    end else begin
      rd = refMem[blk][word];
    end
    if (acked) begin
      a.ack = 2'b00;
      a.ack[m] = 1'b1;
      a.data = rd;
      ackQ.push_back(a);
    end
    favour = (m == 0) ? 1 : 0;
  endtask

  task automatic modelPair(input txn_t t0, input txn_t t1);
    if (favour == 0) begin
      modelTxn(0, t0, 1'b1);
      modelTxn(1, t1, 1'b1);
    end else begin
      modelTxn(1, t1, 1'b1);
      modelTxn(0, t0, 1'b1);
    end
  endtask

  task automatic driveMaster(input int m, input txn_t t, input bit on);
    if (m == 0) begin
      m0Cyc = on; m0Stb = on; m0We = on & t.we; m0Sel = t.sel; m0Adr = t.adr; m0Dat = t.dat;
    end else begin
      m1Cyc = on; m1Stb = on; m1We = on & t.we; m1Sel = t.sel; m1Adr = t.adr; m1Dat = t.dat;
    end
  endtask

  // Request and wait for this master's ack. With hold set, the request is left up for a follow-on call.
  task automatic applyStimulus(input int m, input txn_t t, input bit hold);
    bit got;
    got = 1'b0;
    driveMaster(m, t, 1'b1);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0Ack : m1Ack) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_timeout_m%0d: ack 0, expected 1 within 40 cycles", m);
    end
    if (!hold) driveMaster(m, t, 1'b0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_strobes"}, 32'({mgmtEna, mgmtWen, mgmtWenMask}), 32'd0);
    checkOutput({tag, "_addr"}, 32'(mgmtAddr), 32'd0);
    checkOutput({tag, "_wdata"}, mgmtWdata, 32'd0);
    checkOutput({tag, "_ack_grant"}, 32'({m1Ack, m0Ack, grant}), 32'd0);
    checkOutput({tag, "_m0_dat"}, m0DatO, 32'd0);
    checkOutput({tag, "_m1_dat"}, m1DatO, 32'd0);
  endtask

  function automatic txn_t randTxn();
    txn_t t;
    t.we = 1'($urandom_range(0, 1));
    t.adr = $urandom;
    t.adr[9:4] = 6'd0;
    t.sel = 4'($urandom_range(0, 15));
    t.dat = $urandom;
    return t;
  endfunction

  // Monitor: every strobe and every ack must match the head of its queue.
  always @(negedge clk) begin
    if (mgmtEna != 2'b00) begin
      lastStrobeCycle = cycleCnt;
      if (strobeQ.size() == 0) begin
        checkOutput("strobe_unexpected", 32'(mgmtEna), 32'd0);
      end else begin
        monS = strobeQ.pop_front();
        checkOutput("strobe_ena", 32'(mgmtEna), 32'(monS.ena));
        checkOutput("strobe_wen", 32'(mgmtWen), 32'(monS.wen));
        checkOutput("strobe_mask", 32'(mgmtWenMask), 32'(monS.mask));
        checkOutput("strobe_addr", 32'(mgmtAddr), 32'(monS.addr));
        checkOutput("strobe_wdata", mgmtWdata, monS.wdata);
        checkOutput("strobe_grant", 32'(grant), 32'(monS.grant));
      end
    end else begin
      checkOutput("idle_wen_mask", 32'({mgmtWen, mgmtWenMask}), 32'd0);
    end
    monAckVec = {m1Ack, m0Ack};
    if (monAckVec != 2'b00) begin
      lastAckCycle = cycleCnt;
      if (ackQ.size() == 0) begin
        checkOutput("ack_unexpected", 32'(monAckVec), 32'd0);
      end else begin
        monA = ackQ.pop_front();
        monOwner = monA.ack[1] ? 1 : 0;
        checkOutput("ack_owner", 32'(monAckVec), 32'(monA.ack));
        checkOutput("ack_grant", 32'(grant), 32'(monA.ack));
        checkOutput("ack_data", (monOwner == 1) ? m1DatO : m0DatO, monA.data);
        checkOutput("other_dat_hold", (monOwner == 1) ? m0DatO : m1DatO, lastDat[1 - monOwner]);
        lastDat[monOwner] = monA.data;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    txn_t ta, tb, tc, td;
    int   c0;
    int   kind;

    resetn = 1'b0;
    m0Cyc = 0; m0Stb = 0; m0We = 0; m0Sel = 0; m0Adr = 0; m0Dat = 0;
    m1Cyc = 0; m1Stb = 0; m1We = 0; m1Sel = 0; m1Adr = 0; m1Dat = 0;
    lastDat[0] = 32'd0;
    lastDat[1] = 32'd0;
    for (int b = 0; b < 2; b++) begin
      for (int w = 0; w < 256; w++) begin
        ramMem[b][w] = 32'hA5000000 ^ (b << 16) ^ w;
        refMem[b][w] = 32'hA5000000 ^ (b << 16) ^ w;
      end
    end

    // Reset held for two cycles while both masters request; the first grant afterwards goes to m0.
    ta = '{we: 1'b1, adr: 32'h0000_0410, sel: 4'b1010, dat: $urandom};
    tb = '{we: 1'b0, adr: 32'h0000_0410, sel: 4'b1111, dat: $urandom};
    tc = '{we: 1'b0, adr: 32'h0000_0020, sel: 4'b1111, dat: $urandom};
    td = '{we: 1'b1, adr: 32'hFFFF_F024, sel: 4'b0110, dat: $urandom};
    driveMaster(0, ta, 1'b1);
    driveMaster(1, tb, 1'b1);
    repeat (2) begin
      @(negedge clk);
      checkResetOutputs("reset");
    end
    favour = 0;
    modelPair(ta, tb);
    modelPair(tc, td);
    resetn = 1'b1;
    fork
      begin applyStimulus(0, ta, 1'b1); applyStimulus(0, tc, 1'b0); end
      begin applyStimulus(1, tb, 1'b1); applyStimulus(1, td, 1'b0); end
    join
    @(negedge clk);

    // m0 write to block 1, word 0x41: strobe one cycle after the idle cycle, ack three cycles after.
    ta = '{we: 1'b1, adr: 32'h0000_0504, sel: 4'b0011, dat: 32'hDEADBEEF};
    c0 = cycleCnt;
    modelTxn(0, ta, 1'b1);
    applyStimulus(0, ta, 1'b0);
    @(negedge clk);
    checkOutput("m0wr_strobe_latency", 32'(lastStrobeCycle), 32'(c0 + 1));
    checkOutput("m0wr_ack_latency", 32'(lastAckCycle), 32'(c0 + 3));

    // m1 read of block 0, word 2, which holds 0x12345678.
    ramMem[0][2] = 32'h12345678;
    refMem[0][2] = 32'h12345678;
    tb = '{we: 1'b0, adr: 32'h0000_0008, sel: 4'b1111, dat: 32'h0};
    c0 = cycleCnt;
    modelTxn(1, tb, 1'b1);
    applyStimulus(1, tb, 1'b0);
    @(negedge clk);
    checkOutput("m1rd_strobe_latency", 32'(lastStrobeCycle), 32'(c0 + 1));
    checkOutput("m1rd_ack_latency", 32'(lastAckCycle), 32'(c0 + 3));

    // m1 abandons a write during DATA: the write lands, no ack, and the next tie goes to m0.
    tb = '{we: 1'b1, adr: 32'h0000_0430, sel: 4'b1111, dat: $urandom};
    modelTxn(1, tb, 1'b0);
    driveMaster(1, tb, 1'b1);
    @(negedge clk);
    @(negedge clk);
    driveMaster(1, tb, 1'b0);
    @(negedge clk);
    checkOutput("abort_grant_idle", 32'(grant), 32'd0);
    checkOutput("abort_m1_ack", 32'(m1Ack), 32'd0);
    ta = '{we: 1'b0, adr: 32'h0000_0430, sel: 4'b1111, dat: 32'h0};
    tc = randTxn();
    modelPair(ta, tc);
    fork
      applyStimulus(0, ta, 1'b0);
      applyStimulus(1, tc, 1'b0);
    join
    @(negedge clk);

    // Reset lands while a read is in ISSUE: strobes clear, no ack ever shows, and traffic resumes.
    ta = randTxn();
    ta.we = 1'b0;
    modelTxn(0, ta, 1'b0);
    driveMaster(0, ta, 1'b1);
    @(negedge clk);
    resetn = 1'b0;
    driveMaster(0, ta, 1'b0);
    @(negedge clk);
    checkResetOutputs("rst_issue");
    lastDat[0] = 32'd0;
    lastDat[1] = 32'd0;
    favour = 0;
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    ta = randTxn();
    ta.we = 1'b1;
    tb = ta;
    tb.we = 1'b0;
    modelPair(ta, tb);
    fork
      applyStimulus(0, ta, 1'b0);
      applyStimulus(1, tb, 1'b0);
    join

    // Random rounds: a single master, or both at once.
    for (int r = 0; r < 40; r++) begin
      kind = $urandom_range(0, 2);
      ta = randTxn();
      tb = randTxn();
      if (kind == 0) begin
        modelTxn(0, ta, 1'b1);
        applyStimulus(0, ta, 1'b0);
      end else if (kind == 1) begin
        modelTxn(1, tb, 1'b1);
        applyStimulus(1, tb, 1'b0);
      end else begin
        modelPair(ta, tb);
        fork
          applyStimulus(0, ta, 1'b0);
          applyStimulus(1, tb, 1'b0);
        join
      end
    end

    repeat (6) @(negedge clk);
    checkOutput("strobe_queue_empty", 32'(strobeQ.size()), 32'd0);
    checkOutput("ack_queue_empty", 32'(ackQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
